// File: rtl/fir_ram_pkg.sv
// Shared types and address helpers for the FIR tap delay RAM.
// Exports: state_t (INIT/RUN), tap_slot(), addr_of().
package fir_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slot holding tap 'tap' when the next write goes to 'wptr'.
    // Unsigned wrap followed by the mask gives the mod-DEPTH result.
    function automatic int unsigned tap_slot(
        input int unsigned wptr,
        input int unsigned tap,
        input int unsigned depth
    );
        return (wptr - 32'd1 - tap) & (depth - 32'd1);
    endfunction

    function automatic int unsigned addr_of(
        input int unsigned ch,
        input int unsigned slot,
        input int unsigned tap_w
    );
        return (ch << tap_w) | slot;
    endfunction

endpackage

// File: rtl/ram_1w1r.sv
// Plain synchronous 1-write/1-read array, read-first on address collision.
// Ports: clk, we/waddr/wdata write port, re/raddr/rdata registered read port.
module ram_1w1r #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 256,
    parameter int AW         = (MEM_SIZE < 2) ? 1 : $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

`ifdef FPGA
    (* ram_style = "block" *)
`endif
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/tap_delay_ram.sv
// Multi-channel circular sample buffer; returns any tap (0 = newest).
// Ports: clk/rst_n/clear, busy, in_* write, rd_* read, primed per channel.
module tap_delay_ram
    import fir_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int NUM_CH     = 4,
    parameter int OUT_REG    = 0,
    parameter int CH_W       = (NUM_CH == 1) ? 1 : $clog2(NUM_CH),
    parameter int TAP_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  rd_req,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [TAP_W-1:0]      rd_tap,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [NUM_CH-1:0]     primed
);

    localparam int MEM = NUM_CH * DEPTH;
    localparam int AW  = $clog2(MEM);
    localparam logic [AW-1:0]  LAST = AW'(MEM - 1);
    localparam logic [TAP_W:0] FULL = (TAP_W + 1)'(DEPTH);

    // One bit per encodable channel id, set where the id exists.
    function automatic logic [(1 << CH_W)-1:0] ch_mask();
        logic [(1 << CH_W)-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CH; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [(1 << CH_W)-1:0] CH_MASK = ch_mask();

    state_t                state;
    logic [AW-1:0]         swp;
    logic [TAP_W-1:0]      wptr [NUM_CH];
    logic [TAP_W:0]        cnt  [NUM_CH];

    logic                  in_ok;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [TAP_W-1:0]      wp_in;
    logic [TAP_W-1:0]      wp_rd;
    logic [TAP_W-1:0]      rd_slot;

    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [AW-1:0]         ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  rv1;
    logic                  oob1;
    logic                  seen;
    logic [DATA_WIDTH-1:0] d1;

    assign busy     = (state == INIT);
    assign in_ready = (state == RUN);

    always_comb begin
        in_ok   = CH_MASK[in_ch];
        wp_in   = wptr[in_ch];
        wp_rd   = wptr[rd_ch];
        rd_slot = TAP_W'(tap_slot(32'(wp_rd), 32'(rd_tap), DEPTH));
        wr_acc  = in_valid && (state == RUN) && in_ok;
        rd_acc  = rd_req && (state == RUN);
    end

    // The sweep owns the write port while busy.
    always_comb begin
        ram_we    = busy || wr_acc;
        ram_waddr = busy ? swp
                         : AW'(addr_of(32'(in_ch), 32'(wp_in), TAP_W));
        ram_wdata = busy ? '0 : in_data;
        ram_raddr = AW'(addr_of(32'(rd_ch), 32'(rd_slot), TAP_W));
    end

    ram_1w1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            swp   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else if (clear) begin
            state <= INIT;
            swp   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else if (state == INIT) begin
            if (swp == LAST) begin
                state <= RUN;
                swp   <= '0;
            end else begin
                swp <= swp + 1'b1;
            end
        end else if (wr_acc) begin
            wptr[in_ch] <= wp_in + 1'b1;
            if (cnt[in_ch] != FULL) cnt[in_ch] <= cnt[in_ch] + 1'b1;
        end
    end

    always_comb begin
        primed = '0;
        for (int c = 0; c < NUM_CH; c++) primed[c] = (cnt[c] == FULL);
    end

    // 'seen' masks the unreset RAM output until a real read lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1  <= 1'b0;
            oob1 <= 1'b0;
            seen <= 1'b0;
        end else begin
            rv1 <= rd_acc;
            if (rd_acc) begin
                oob1 <= !CH_MASK[rd_ch];
                seen <= 1'b1;
            end
        end
    end

    assign d1 = (oob1 || !seen) ? '0 : ram_q;

    if (OUT_REG != 0) begin : g_oreg
        logic                  rv2;
        logic [DATA_WIDTH-1:0] dq;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv2 <= 1'b0;
                dq  <= '0;
            end else begin
                rv2 <= rv1;
                if (rv1) dq <= d1;
            end
        end

        assign rd_valid = rv2;
        assign rd_data  = dq;
    end else begin : g_direct
        assign rd_valid = rv1;
        assign rd_data  = d1;
    end

endmodule

// File: tb/tb_tap_delay_ram.sv
// Bench for tap_delay_ram: DEPTH=8, NUM_CH=2, OUT_REG=0 and 1 side by side.
// History-queue model checked every cycle plus directed literal checks.
module tb_tap_delay_ram;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        rd_req = 1'b0;
    logic [0:0]  rd_ch = '0;
    logic [2:0]  rd_tap = '0;

    logic        busy0, ready0, rv0, busy1, ready1, rv1;
    logic [15:0] rd0, rd1;
    logic [1:0]  pr0, pr1;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tap_delay_ram #(
        .DATA_WIDTH(16), .DEPTH(8), .NUM_CH(2), .OUT_REG(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0),
        .in_valid(in_valid), .in_ready(ready0), .in_ch(in_ch),
        .in_data(in_data), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_tap(rd_tap), .rd_valid(rv0), .rd_data(rd0), .primed(pr0)
    );

    tap_delay_ram #(
        .DATA_WIDTH(16), .DEPTH(8), .NUM_CH(2), .OUT_REG(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
        .in_valid(in_valid), .in_ready(ready1), .in_ch(in_ch),
        .in_data(in_data), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_tap(rd_tap), .rd_valid(rv1), .rd_data(rd1), .primed(pr1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: per-channel history, index 0 = newest sample.
    logic [15:0] hist [2][8];
    int          fill [2];
    int          busy_left;
    logic        mv0, pv, mv1;
    logic [15:0] md0, pd, md1;

    task automatic model_wipe();
        for (int c = 0; c < 2; c++) begin
            fill[c] = 0;
            for (int t = 0; t < 8; t++) hist[c][t] = '0;
        end
    endtask

    task automatic model_reset();
        model_wipe();
        busy_left = N;
        mv0 = 1'b0; md0 = '0;
        pv  = 1'b0; pd  = '0;
        mv1 = 1'b0; md1 = '0;
    endtask

    task automatic model_edge();
        logic        nv;
        logic [15:0] val;
        nv  = rd_req && (busy_left == 0);
        val = hist[rd_ch][rd_tap];
        mv0 = nv;
        if (nv) md0 = val;
        mv1 = pv;
        if (pv) md1 = pd;
        pv = nv;
        if (nv) pd = val;
        if (in_valid && busy_left == 0) begin
            for (int t = 7; t > 0; t--) hist[in_ch][t] = hist[in_ch][t-1];
            hist[in_ch][0] = in_data;
            if (fill[in_ch] < 8) fill[in_ch]++;
        end
        if (clear) begin
            model_wipe();
            busy_left = N;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    initial begin
        logic [1:0] epr;
        forever begin
            @(negedge clk);
            epr = {fill[1] >= 8, fill[0] >= 8};
            chk("u0_busy", 32'(busy0), 32'(busy_left > 0));
            chk("u0_ready", 32'(ready0), 32'(busy_left == 0));
            chk("u0_primed", 32'(pr0), 32'(epr));
            chk("u0_rvalid", 32'(rv0), 32'(mv0));
            chk("u0_rdata", 32'(rd0), 32'(md0));
            chk("u1_busy", 32'(busy1), 32'(busy_left > 0));
            chk("u1_ready", 32'(ready1), 32'(busy_left == 0));
            chk("u1_primed", 32'(pr1), 32'(epr));
            chk("u1_rvalid", 32'(rv1), 32'(mv1));
            chk("u1_rdata", 32'(rd1), 32'(md1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high; caller is just past an edge.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy0) break;
            n++;
        end
        chk(name, 32'(n), 32'd16);
        chk({name, "_ready"}, 32'(ready0), 32'd1);
        step();
    endtask

    task automatic do_write(input logic ch, input logic [15:0] d);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_read(input logic ch, input logic [2:0] tap,
                           input logic [15:0] exp, input string name);
        rd_req = 1'b1;
        rd_ch  = ch;
        rd_tap = tap;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        chk({name, "_v"}, 32'(rv0), 32'd1);
        chk(name, 32'(rd0), 32'(exp));
        step();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_rvalid", 32'(rv1), 32'd0);
        chk("rst_rdata", 32'(rd1), 32'd0);
        chk("rst_primed", 32'(pr0), 32'd0);
        rst_n = 1'b1;
        count_busy("init_len");
        do_read(1'b1, 3'd5, 16'd0, "rd_zero");

        for (int i = 1; i <= 10; i++) begin
            do_write(1'b0, 16'(i));
            if (i == 7) chk("primed_7", 32'(pr0), 32'd0);
            if (i == 8) chk("primed_8", 32'(pr0), 32'd1);
        end
        for (int t = 0; t < 8; t++)
            do_read(1'b0, 3'(t), 16'(10 - t), "tap_wrap");

        do_write(1'b1, 16'd100);
        do_write(1'b1, 16'd101);
        do_write(1'b1, 16'd102);
        do_read(1'b1, 3'd0, 16'd102, "ch1_t0");
        do_read(1'b1, 3'd2, 16'd100, "ch1_t2");
        do_read(1'b1, 3'd3, 16'd0, "ch1_t3");
        do_read(1'b0, 3'd0, 16'd10, "ch0_keep");

        in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd11;
        rd_req = 1'b1; rd_ch = 1'b0; rd_tap = 3'd7;
        step();
        in_valid = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_first", 32'(rd0), 32'd3);
        step();
        do_read(1'b0, 3'd0, 16'd11, "new_t0");
        do_read(1'b0, 3'd7, 16'd4, "new_t7");

        // Back-to-back: u1 shows tap k-1 just after edge k.
        rd_ch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd_req = (k < 8);
            rd_tap = 3'(k);
            @(posedge clk);
            #1;
            if (k >= 1 && k <= 8) begin
                chk("b2b_v", 32'(rv1), 32'd1);
                chk("b2b_d", 32'(rd1), 32'(12 - k));
            end else begin
                chk("b2b_idle", 32'(rv1), 32'd0);
            end
        end
        rd_req = 1'b0;

        clear = 1'b1;
        step();
        clear = 1'b0;
        count_busy("clr_len");
        chk("clr_primed", 32'(pr0), 32'd0);
        do_read(1'b0, 3'd0, 16'd0, "clr_ch0");
        do_read(1'b1, 3'd0, 16'd0, "clr_ch1");

        do_write(1'b0, 16'd55);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        count_busy("reclr_len");

        do_write(1'b0, 16'd77);
        do_write(1'b0, 16'd78);
        rd_req = 1'b1; rd_ch = 1'b0; rd_tap = 3'd0;
        repeat (3) step();
        chk("pre_rst_d", 32'(rd1), 32'd78);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_v1", 32'(rv1), 32'd0);
        chk("arst_d1", 32'(rd1), 32'd0);
        chk("arst_v0", 32'(rv0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd1);
        rd_req = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        count_busy("rerst_len");
        do_read(1'b0, 3'd0, 16'd0, "post_rst");
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
